calc2_req_driver: RTL
=====================

// Module: calc2_req_driver
// PURPOSE
//  Upstream request driver for one calc2_top requester port; instantiated once per port (x4).
//  Buffers operand requests, allocates 2-bit tags and sequences the two-cycle calc2 command protocol (cmd+tag+op1, then op2).
//  Matches responses back to their tag table entry and emits one completion per issued command.
// PARAMETERS
//  FIFO_DEPTH      4   request FIFO entries (power of 2, >=2)
//  TIMEOUT_CYCLES  64  response watchdog limit in c_clk cycles (used only with CALC2_RESP_TIMEOUT_EN)
// PORTS
//  c_clk         in   1   clock
//  reset         in   1   synchronous reset, active-high
//  req_valid     in   1   request present
//  req_ready     out  1   FIFO not full; transfer when req_valid & req_ready
//  req_cmd       in   4   calc2 command
//  req_op1       in   32  operand 1
//  req_op2       in   32  operand 2
//  reqN_cmd_in   out  4   to calc2 reqN_cmd_in
//  reqN_data_in  out  32  to calc2 reqN_data_in
//  reqN_tag_in   out  2   to calc2 reqN_tag_in
//  out_resp      in   2   from calc2 out_respN (00 = none)
//  out_data      in   32  from calc2 out_dataN
//  out_tag       in   2   from calc2 out_tagN
//  cpl_valid     out  1   one-cycle completion strobe, no backpressure
//  cpl_resp      out  2   01 ok, 10 calc2 error, 11 timeout
//  cpl_data      out  32  result (0 on timeout)
//  cpl_tag       out  2   tag of the completed command
//  cpl_cmd       out  4   command recalled from tag table
//  busy_tags     out  4   outstanding-tag bitmap
//  spurious_err  out  1   sticky: response seen on a non-busy tag
//  timeout_err   out  1   sticky: a watchdog expired
// BEHAVIOUR
//  - Reset (c_clk edge with reset=1): FIFO empty, FSM IDLE, all reqN_* outputs 0, busy_tags 0, cpl_* 0, both sticky flags 0.
//  - All outputs are registered. Reset mid-command drops the in-flight op2 cycle and all outstanding tags without completions.
//  - FIFO: write on req_valid&req_ready; req_ready = !full. Simultaneous push and pop when full: pop happens, push refused (ready already 0).
//  - FSM IDLE: if FIFO non-empty and a free tag exists -> CMD. Tag = lowest-index bit clear in busy_tags.
//  - FSM CMD (1 cycle): drive cmd/tag/op1; set busy bit; store cmd in tag table; pop FIFO -> OP2.
//  - FSM OP2 (1 cycle): drive cmd=0, tag=0, data=op2. Next state is CMD if the IDLE condition holds (back-to-back), else IDLE.
//  - In IDLE, outputs are cmd=0, data=0, tag=0.
//  - FIFO entries with req_cmd==0 are popped in IDLE with no issue, no tag and no completion.
//  - Response: out_resp!=0 -> next cycle cpl_valid=1 with cpl_resp=out_resp, cpl_data=out_data, cpl_tag=out_tag, cpl_cmd=table[out_tag]; busy bit cleared.
//  - Response on a non-busy tag: spurious_err set, no completion, busy unchanged.
//  - Free and allocate in the same cycle: allocation uses busy_tags from the start of the cycle; the freed tag is allocatable next cycle.
//  - All 4 tags busy: FSM waits in IDLE, FIFO fills, req_ready drops at FIFO_DEPTH entries.
// CONFIGURATION
//  CALC2_RESP_TIMEOUT_EN defined:
//  - per-tag counter starts at 0 on CMD and increments while busy.
//  - At TIMEOUT_CYCLES: busy bit freed, completion cpl_resp=11, cpl_data=0, timeout_err set.
//  - A real response arriving in the same cycle takes priority.
//  - A late response after a timeout counts as spurious.
//  CALC2_RESP_TIMEOUT_EN undefined: no counters, tags held until responded, cpl_resp never 11, timeout_err tied 0.
// TESTING
//  1 reset 3 cycles, then single add (cmd 1, op1 5, op2 7), calc2 replies resp 01 data 12
//    -> bus cmd1/tag0/5 then cmd0/7; cpl 01/12/tag0/cmd1; busy returns 0
//  2 push 6 requests back-to-back, no responses
//    -> tags 0,1,2,3 issued on consecutive 2-cycle slots; busy=1111
//    -> req_ready low once FIFO holds 4; responding tag 2 lets the next request issue with tag 2
//  3 response on tag 1 in the same cycle tag 3 is allocated
//    -> tag 3 issued, tag1 freed, cpl_tag=1 next cycle
//  4 inject out_resp=01 with out_tag=2 while busy=0001 -> spurious_err=1, no cpl_valid
//  5 (CALC2_RESP_TIMEOUT_EN, TIMEOUT_CYCLES=8) issue sub, withhold response
//    -> 8 cycles later cpl_resp=11, cpl_data=0, timeout_err=1, tag freed
//  6 assert reset during OP2 with 2 tags busy
//    -> next cycle all outputs 0, busy=0, no completions emitted

Source files
------------

// File: rtl/calc2_req_driver.sv
// calc2_req_driver: upstream request driver for one calc2_top requester port.
// Buffers requests in a FIFO, allocates 2-bit tags, drives the two-cycle
// cmd+tag+op1 / op2 bus sequence and turns calc2 responses into completions.
//
// Ports:
//   c_clk, reset                   clock, synchronous active-high reset
//   req_valid/req_ready            request handshake (ready = FIFO not full)
//   req_cmd, req_op1, req_op2      request payload
//   reqN_cmd_in/data_in/tag_in     registered bus to calc2 requester port
//   out_resp, out_data, out_tag    calc2 response (out_resp 00 = none)
//   cpl_valid/resp/data/tag/cmd    one-cycle completion strobe and payload
//   busy_tags                      outstanding-tag bitmap
//   spurious_err, timeout_err      sticky error flags
//
// Optional feature: define CALC2_RESP_TIMEOUT_EN to enable the per-tag
// response watchdog (TIMEOUT_CYCLES). Without it tags are held until a
// response arrives and timeout_err is tied low.

module calc2_req_driver #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_cmd,
    input  logic [31:0] req_op1,
    input  logic [31:0] req_op2,
    output logic [3:0]  reqN_cmd_in,
    output logic [31:0] reqN_data_in,
    output logic [1:0]  reqN_tag_in,
    input  logic [1:0]  out_resp,
    input  logic [31:0] out_data,
    input  logic [1:0]  out_tag,
    output logic        cpl_valid,
    output logic [1:0]  cpl_resp,
    output logic [31:0] cpl_data,
    output logic [1:0]  cpl_tag,
    output logic [3:0]  cpl_cmd,
    output logic [3:0]  busy_tags,
    output logic        spurious_err,
    output logic        timeout_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        OP2
    } state_t;

    state_t state;

    logic [3:0]    fifo_cmd [FIFO_DEPTH];
    logic [31:0]   fifo_op1 [FIFO_DEPTH];
    logic [31:0]   fifo_op2 [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [31:0]   op2_q;
    logic [3:0]    tag_cmd [4];

    logic       push;
    logic       pop;
    logic       nonempty;
    logic       can_issue;
    logic       issue;
    logic       drop;
    logic       resp_hit;
    logic       resp_spur;
    logic [3:0] head_cmd;
    logic [1:0] alloc_tag;
    logic [3:0] alloc_mask;
    logic [3:0] free_mask;
    logic       to_now;
    logic [1:0] to_tag;

    assign req_ready = (count != FULL_CNT);
    assign push      = req_valid && req_ready;
    assign nonempty  = (count != '0);
    assign head_cmd  = fifo_cmd[rd_ptr];

    // Allocation looks at busy_tags as registered; a tag freed this cycle
    // only becomes allocatable on the next one.
    assign can_issue = nonempty && (head_cmd != 4'd0)
                     && (busy_tags != 4'hF);
    assign issue     = (state != CMD) && can_issue;
    // Zero-command entries are discarded without touching the bus.
    assign drop      = (state == IDLE) && nonempty
                     && (head_cmd == 4'd0);
    assign pop       = issue || drop;

    assign resp_hit  = (out_resp != 2'b00) && busy_tags[out_tag];
    assign resp_spur = (out_resp != 2'b00) && !busy_tags[out_tag];

    always_comb begin
        alloc_tag = 2'd3;
        if (!busy_tags[0])      alloc_tag = 2'd0;
        else if (!busy_tags[1]) alloc_tag = 2'd1;
        else if (!busy_tags[2]) alloc_tag = 2'd2;
    end

    always_comb begin
        alloc_mask = 4'b0000;
        free_mask  = 4'b0000;
        if (issue)
            alloc_mask = 4'b0001 << alloc_tag;
        if (resp_hit)
            free_mask = 4'b0001 << out_tag;
        else if (to_now)
            free_mask = 4'b0001 << to_tag;
    end

`ifdef CALC2_RESP_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] AGE_MAX = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] age [4];
    logic [3:0]    expired;

    // A real response wins the completion slot; an expired tag that
    // loses it stays saturated and fires on a later quiet cycle.
    always_comb begin
        for (int i = 0; i < 4; i++)
            expired[i] = busy_tags[i] && (age[i] == AGE_MAX);
        to_tag = 2'd3;
        if (expired[0])      to_tag = 2'd0;
        else if (expired[1]) to_tag = 2'd1;
        else if (expired[2]) to_tag = 2'd2;
        to_now = (expired != 4'b0000) && !resp_hit;
    end

    always_ff @(posedge c_clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++)
                age[i] <= '0;
            timeout_err <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (alloc_mask[i])
                    age[i] <= '0;
                else if (busy_tags[i] && age[i] != AGE_MAX)
                    age[i] <= age[i] + 1'b1;
            end
            if (to_now)
                timeout_err <= 1'b1;
        end
    end
`else
    assign to_now      = 1'b0;
    assign to_tag      = 2'd0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge c_clk) begin
        if (push) begin
            fifo_cmd[wr_ptr] <= req_cmd;
            fifo_op1[wr_ptr] <= req_op1;
            fifo_op2[wr_ptr] <= req_op2;
        end
        if (issue)
            tag_cmd[alloc_tag] <= head_cmd;
    end

    always_ff @(posedge c_clk) begin
        if (reset) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            op2_q        <= '0;
            reqN_cmd_in  <= '0;
            reqN_data_in <= '0;
            reqN_tag_in  <= '0;
            busy_tags    <= '0;
            cpl_valid    <= 1'b0;
            cpl_resp     <= '0;
            cpl_data     <= '0;
            cpl_tag      <= '0;
            cpl_cmd      <= '0;
            spurious_err <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;

            busy_tags <= (busy_tags & ~free_mask) | alloc_mask;

            if (resp_spur)
                spurious_err <= 1'b1;

            cpl_valid <= resp_hit || to_now;
            if (resp_hit) begin
                cpl_resp <= out_resp;
                cpl_data <= out_data;
                cpl_tag  <= out_tag;
                cpl_cmd  <= tag_cmd[out_tag];
            end else if (to_now) begin
                cpl_resp <= 2'b11;
                cpl_data <= '0;
                cpl_tag  <= to_tag;
                cpl_cmd  <= tag_cmd[to_tag];
            end else begin
                cpl_resp <= '0;
                cpl_data <= '0;
                cpl_tag  <= '0;
                cpl_cmd  <= '0;
            end

            unique case (state)
                CMD: begin
                    state        <= OP2;
                    reqN_cmd_in  <= '0;
                    reqN_tag_in  <= '0;
                    reqN_data_in <= op2_q;
                end
                IDLE, OP2: begin
                    if (issue) begin
                        state        <= CMD;
                        reqN_cmd_in  <= head_cmd;
                        reqN_tag_in  <= alloc_tag;
                        reqN_data_in <= fifo_op1[rd_ptr];
                        op2_q        <= fifo_op2[rd_ptr];
                    end else begin
                        state        <= IDLE;
                        reqN_cmd_in  <= '0;
                        reqN_tag_in  <= '0;
                        reqN_data_in <= '0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    reqN_cmd_in  <= '0;
                    reqN_tag_in  <= '0;
                    reqN_data_in <= '0;
                end
            endcase
        end
    end

endmodule
